// File: rtl/fp_align_stage_pkg.sv
// Shared single-precision FPU field widths used by the add/sub datapath stages.
package fp_align_stage_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_GRS_W = 3;
  localparam int FP_SIG_W = FP_MAN_W + 1;
  localparam int FP_ALN_W = FP_SIG_W + FP_GRS_W;

endpackage

// File: rtl/fp_align_stage_cmp.sv
// Team unsigned magnitude comparator: o_lt when i_a < i_b, o_ge otherwise.
module fp_align_stage_cmp #(
  parameter int SIZE = 31
) (
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  output logic            o_lt,
  output logic            o_ge
);

  always_comb begin
    o_lt = (i_a < i_b);
    o_ge = ~o_lt;
  end

endmodule

// File: rtl/fp_align_stage.sv
// FP add alignment stage: S1 unpacks and orders operands by magnitude,
// S2 right-shifts the smaller significand by the exponent gap with sticky.
module fp_align_stage
  import fp_align_stage_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       a,
  input  logic [EXP_W+MAN_W:0]       b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       big_sign,
  output logic [EXP_W-1:0]           big_exp,
  output logic [MAN_W:0]             big_man,
  output logic                       small_sign,
  output logic [MAN_W+FP_GRS_W:0]    small_man,
  output logic [EXP_W-1:0]           exp_diff,
  output logic                       swapped,
  output logic                       out_special
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int ALN_W = SIG_W + FP_GRS_W;

  logic w_a_lt, w_a_ge;
  logic w_s1_load, w_s2_load;

  logic [W-1:0]     w_big, w_small;
  logic [EXP_W-1:0] w_big_fexp, w_small_fexp;

  logic             r1_valid;
  logic             r1_big_sign, r1_small_sign, r1_swapped, r1_special;
  logic [EXP_W-1:0] r1_big_exp, r1_small_exp;
  logic [SIG_W-1:0] r1_big_man, r1_small_man;

  logic             r2_valid;

  logic [EXP_W-1:0] w_diff;
  logic [ALN_W-1:0] w_ext, w_shift, w_mask, w_aligned;

  fp_align_stage_cmp #(.SIZE(W-1)) u_cmp (
    .i_a  (a[W-2:0]),
    .i_b  (b[W-2:0]),
    .o_lt (w_a_lt),
    .o_ge (w_a_ge)
  );

  assign w_s2_load = ~r2_valid | out_ready;
  assign w_s1_load = ~r1_valid | w_s2_load;
  assign in_ready  = ~rst & w_s1_load;
  assign out_valid = r2_valid;

  always_comb begin
    w_big        = w_a_lt ? b : a;
    w_small      = w_a_ge ? b : a;
    w_big_fexp   = w_big[W-2 -: EXP_W];
    w_small_fexp = w_small[W-2 -: EXP_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid      <= 1'b0;
      r1_big_sign   <= 1'b0;
      r1_small_sign <= 1'b0;
      r1_swapped    <= 1'b0;
      r1_special    <= 1'b0;
      r1_big_exp    <= '0;
      r1_small_exp  <= '0;
      r1_big_man    <= '0;
      r1_small_man  <= '0;
    end else if (w_s1_load) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_big_sign   <= w_big[W-1];
        r1_small_sign <= w_small[W-1];
        r1_swapped    <= w_a_lt;
        r1_special    <= (a[W-2 -: EXP_W] == '1) | (b[W-2 -: EXP_W] == '1);
        // Denormals use effective exponent 1 with a zero hidden bit.
        r1_big_exp    <= (w_big_fexp == '0) ? EXP_W'(1) : w_big_fexp;
        r1_small_exp  <= (w_small_fexp == '0) ? EXP_W'(1) : w_small_fexp;
        r1_big_man    <= {(w_big_fexp != '0), w_big[MAN_W-1:0]};
        r1_small_man  <= {(w_small_fexp != '0), w_small[MAN_W-1:0]};
      end
    end
  end

  always_comb begin
    w_diff    = r1_big_exp - r1_small_exp;
    w_ext     = {r1_small_man, {FP_GRS_W{1'b0}}};
    w_shift   = '0;
    w_mask    = '0;
    w_aligned = '0;
    // Beyond the field width every bit is shifted out, leaving only sticky.
    if (int'(w_diff) >= ALN_W) begin
      w_aligned = {{(ALN_W-1){1'b0}}, |w_ext};
    end else begin
      w_shift   = w_ext >> w_diff;
      w_mask    = (ALN_W'(1) << w_diff) - ALN_W'(1);
      w_aligned = {w_shift[ALN_W-1:1], w_shift[0] | (|(w_ext & w_mask))};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid    <= 1'b0;
      big_sign    <= 1'b0;
      big_exp     <= '0;
      big_man     <= '0;
      small_sign  <= 1'b0;
      small_man   <= '0;
      exp_diff    <= '0;
      swapped     <= 1'b0;
      out_special <= 1'b0;
    end else if (w_s2_load) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        big_sign    <= r1_big_sign;
        big_exp     <= r1_big_exp;
        big_man     <= r1_big_man;
        small_sign  <= r1_small_sign;
        small_man   <= w_aligned;
        exp_diff    <= w_diff;
        swapped     <= r1_swapped;
        out_special <= r1_special;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// Self-checking bench for fp_align_stage: directed cases plus random traffic
// against an arithmetic reference model with an in-order scoreboard.
module tb_fp_align_stage;

  typedef struct packed {
    logic        big_sign;
    logic [7:0]  big_exp;
    logic [23:0] big_man;
    logic        small_sign;
    logic [26:0] small_man;
    logic [7:0]  exp_diff;
    logic        swapped;
    logic        special;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b;
  logic        big_sign, small_sign, swapped, out_special;
  logic [7:0]  big_exp, exp_diff;
  logic [23:0] big_man;
  logic [26:0] small_man;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  res_t        exp_q[$];
  int unsigned acc_q[$];
  bit          lat_chk = 1'b0;
  bit          hold_pending = 1'b0;
  res_t        held;
  res_t        last_out;
  logic        s_ov, s_ir;

  always #5 clk = ~clk;

  fp_align_stage #(.EXP_W(8), .MAN_W(23)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .big_sign    (big_sign),
    .big_exp     (big_exp),
    .big_man     (big_man),
    .small_sign  (small_sign),
    .small_man   (small_man),
    .exp_diff    (exp_diff),
    .swapped     (swapped),
    .out_special (out_special)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic res_t ref_model(input logic [31:0] x, input logic [31:0] y);
    res_t            r;
    logic [31:0]     bg, sm;
    int unsigned     eb, es, sb, ss, d;
    longint unsigned ext, p, v;
    r.swapped = (x & 32'h7FFF_FFFF) < (y & 32'h7FFF_FFFF);
    bg = r.swapped ? y : x;
    sm = r.swapped ? x : y;
    eb = (bg >> 23) & 32'hFF;
    es = (sm >> 23) & 32'hFF;
    sb = (bg & 32'h7F_FFFF) + ((eb != 0) ? 32'h80_0000 : 32'h0);
    ss = (sm & 32'h7F_FFFF) + ((es != 0) ? 32'h80_0000 : 32'h0);
    if (eb == 0) eb = 1;
    if (es == 0) es = 1;
    d = eb - es;
    if (d >= 27) begin
      v = (ss != 0) ? 64'd1 : 64'd0;
    end else begin
      ext = longint'(ss) * 8;
      p   = 64'd1 << d;
      v   = ext / p;
      if (ext % p != 0) v = v | 64'd1;
    end
    r.big_sign   = bg[31];
    r.small_sign = sm[31];
    r.big_exp    = 8'(eb);
    r.big_man    = 24'(sb);
    r.small_man  = 27'(v);
    r.exp_diff   = 8'(d);
    r.special    = (((x >> 23) & 32'hFF) == 255) || (((y >> 23) & 32'hFF) == 255);
    return r;
  endfunction

  // One clock cycle: drive at negedge, sample 1 ns later, score transfers.
  task automatic step(input logic v, input logic [31:0] av, input logic [31:0] bv,
                      input logic ordy, input logic rs, output logic acc);
    res_t got;
    @(negedge clk);
    rst = rs; in_valid = v; a = av; b = bv; out_ready = ordy;
    #1;
    got = '{big_sign, big_exp, big_man, small_sign, small_man, exp_diff, swapped, out_special};
    s_ov = out_valid;
    s_ir = in_ready;
    acc  = 1'b0;
    if (hold_pending) begin
      check_eq("hold_valid", {127'd0, out_valid}, 128'd1);
      check_eq("hold_data", 128'(got), 128'(held));
    end
    if (rs) begin
      check_eq("rst_in_ready", {127'd0, in_ready}, 128'd0);
      exp_q.delete();
      acc_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", {127'd0, out_valid}, 128'd0);
        end else begin
          res_t        e;
          int unsigned ac;
          e  = exp_q.pop_front();
          ac = acc_q.pop_front();
          check_eq("result", 128'(got), 128'(e));
          if (lat_chk) check_eq("latency", 128'(cyc - ac), 128'd2);
        end
        last_out = got;
      end
      hold_pending = out_valid && !out_ready;
      held = got;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(av, bv));
        acc_q.push_back(cyc);
        acc = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    logic acc;
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      n++;
    end
    check_eq("drain_done", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic run_one(input logic [31:0] av, input logic [31:0] bv);
    logic acc;
    step(1'b1, av, bv, 1'b1, 1'b0, acc);
    check_eq("accept", {127'd0, acc}, 128'd1);
    drain();
  endtask

  function automatic logic [31:0] rand_op(input logic [7:0] near);
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 7))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3:    e = near + 8'($urandom_range(0, 6)) - 8'd3;
      4:       e = near + 8'($urandom_range(20, 35));
      default: e = 8'($urandom_range(0, 255));
    endcase
    m = ($urandom_range(0, 5) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        acc;
    logic [31:0] pa, pb;
    logic        pend;
    logic [31:0] bpa[3];
    logic [31:0] bpb[3];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check_eq("reset_out_valid", {127'd0, s_ov}, 128'd0);
    check_eq("reset_in_ready", {127'd0, s_ir}, 128'd1);
    check_eq("reset_data", 128'(held), 128'd0);

    lat_chk = 1'b1;
    run_one(32'h3F80_0000, 32'h3F00_0000);
    check_eq("d1_fields", 128'({last_out.swapped, last_out.big_exp, last_out.big_man,
                                last_out.exp_diff, last_out.small_man}),
             128'({1'b0, 8'd127, 24'h80_0000, 8'd1, 27'h200_0000}));
    run_one(32'h3F00_0000, 32'h3F80_0000);
    check_eq("d2_fields", 128'({last_out.swapped, last_out.big_exp, last_out.big_man,
                                last_out.exp_diff, last_out.small_man}),
             128'({1'b1, 8'd127, 24'h80_0000, 8'd1, 27'h200_0000}));
    run_one(32'h4B80_0000, 32'h3F80_0001);
    check_eq("d3_sticky", 128'({last_out.exp_diff, last_out.small_man}),
             128'({8'd24, 27'h000_0005}));
    run_one(32'h7F00_0000, 32'h3F80_0000);
    check_eq("d4_far", 128'(last_out.small_man), 128'd1);
    run_one(32'hC040_0000, 32'hC040_0000);
    check_eq("d5_equal", 128'({last_out.swapped, last_out.exp_diff, last_out.big_sign,
                               last_out.small_sign, last_out.small_man}),
             128'({1'b0, 8'd0, 1'b1, 1'b1, 27'h600_0000}));
    run_one(32'h7F80_0000, 32'h3F80_0000);
    check_eq("d6_special", {127'd0, last_out.special}, 128'd1);
    run_one(32'h3F80_0000, 32'h4000_0000);
    check_eq("d7_nospecial", {127'd0, last_out.special}, 128'd0);

    // Back-pressure: three back-to-back pairs, consumer stalled for 4 cycles.
    lat_chk = 1'b0;
    bpa[0] = 32'h4120_0000; bpb[0] = 32'h3F80_0000;
    bpa[1] = 32'hBF80_0000; bpb[1] = 32'h4248_0000;
    bpa[2] = 32'h0000_0123; bpb[2] = 32'h0080_0000;
    step(1'b1, bpa[0], bpb[0], 1'b0, 1'b0, acc);
    check_eq("bp_acc0", {127'd0, acc}, 128'd1);
    step(1'b1, bpa[1], bpb[1], 1'b0, 1'b0, acc);
    check_eq("bp_acc1", {127'd0, acc}, 128'd1);
    step(1'b1, bpa[2], bpb[2], 1'b0, 1'b0, acc);
    check_eq("bp_stall0", {127'd0, acc}, 128'd0);
    step(1'b1, bpa[2], bpb[2], 1'b0, 1'b0, acc);
    check_eq("bp_stall1", {127'd0, acc}, 128'd0);
    for (int i = 0; i < 4 && !acc; i++) step(1'b1, bpa[2], bpb[2], 1'b1, 1'b0, acc);
    check_eq("bp_acc2", {127'd0, acc}, 128'd1);
    drain();

    // Random traffic with random back-pressure.
    pend = 1'b0; pa = '0; pb = '0;
    for (int i = 0; i < 600; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        pa = rand_op(8'($urandom_range(1, 254)));
        pb = rand_op(pa[30:23]);
        if ($urandom_range(0, 9) == 0) pb = pa ^ {1'($urandom_range(0, 1)), 31'd0};
      end
      step(v, pa, pb, 1'($urandom_range(0, 2) != 0), 1'b0, acc);
      pend = v && !acc;
    end
    drain();

    // Reset with two pairs in flight: nothing may emerge afterwards.
    step(1'b1, 32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b0, acc);
    check_eq("rm_acc0", {127'd0, acc}, 128'd1);
    step(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b0, 1'b0, acc);
    check_eq("rm_acc1", {127'd0, acc}, 128'd1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check_eq("rm_out_valid", {127'd0, s_ov}, 128'd0);
    check_eq("rm_in_ready", {127'd0, s_ir}, 128'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      check_eq("rm_no_emerge", {127'd0, s_ov}, 128'd0);
    end

    check_eq("final_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
